spart_rx: RTL and testbench

Serial receive stage of the SPART. Consumes the periodic one-cycle enable tick from the baud rate generator as an oversampling strobe and deserializes the asynchronous `rxd` line into bytes. Frame format is 8N1: start bit, 8 data bits LSB first, then stop bit. Received bytes are presented to the bus interface with a receive-data-available flag, framing/overrun status and a read-acknowledge handshake.

---
 rtl/spart_pkg.sv | 15 +
 rtl/spart_sync.sv | 23 ++
 rtl/spart_rx.sv | 167 ++++++++++++++++
 tb/tb_spart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART types and default framing constants.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int SPART_OVERSAMPLE = 16;
    localparam int SPART_DATA_BITS  = 8;

endpackage

// File: rtl/spart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to the line's idle level.
module spart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 deserializer with rda/framing/overrun status.
// Define SPART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int DATA_BITS  = SPART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
`ifdef SPART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rxd_s;
    logic                 rxd_prev;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done;
`ifdef SPART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    spart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Edge history is kept in every state so a line stuck low never looks like a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_prev <= 1'b1;
        end else if (baud_en) begin
            rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef SPART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef SPART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
`ifdef SPART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (baud_en) begin
            case (state_q)
                IDLE: begin
                    if (rxd_prev && !rxd_s) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == HALF_M1) begin
                        // From here the counter wraps exactly at each bit centre.
                        if (!rxd_s) begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        par_d   = rxd_s;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completing byte takes priority over a same-cycle rd_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rda        <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (done) begin
            rx_data    <= shift_q;
            rda        <= 1'b1;
            frame_err  <= ~rxd_s;
            overrun    <= rda & ~rd_ack;
`ifdef SPART_RX_PARITY_EN
            parity_err <= ^{shift_q, par_q};
`endif
        end else if (rd_ack && rda) begin
            rda        <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: normal, false start, framing, overrun, reset mid-frame, continuous tick.
`timescale 1ns/1ps
module tb_spart_rx;
    import spart_pkg::*;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;
`ifdef SPART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;
    int baud_div = 29;
    int bcnt = 0;
    bit ack_hit = 1'b0;

    spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_en   (baud_en),
        .rxd       (rxd),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SPART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (bcnt >= baud_div - 1) begin
                baud_en = 1'b1;
                bcnt    = 0;
            end else begin
                baud_en = 1'b0;
                bcnt    = bcnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        wait_clks(n * OS * baud_div);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        wait_clks(2);
    endtask

    // Leaves rxd at the stop-bit level; optionally pulses rd_ack on the completing tick.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input bit ack_at_done);
        rxd = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_bits(1);
        end
`ifdef SPART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        wait_bits(1);
`endif
        rxd = stop_bit;
        ack_hit = 1'b0;
        for (int c = 0; c < OS * baud_div; c++) begin
            @(negedge clk);
            rd_ack = 1'b0;
            #1;
            if (ack_at_done && !ack_hit && dut.state_q == STOP && dut.cnt_q == 4'hF && baud_en) begin
                rd_ack  = 1'b1;
                ack_hit = 1'b1;
            end
        end
        rd_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_clks(3);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rda", 32'(rda), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef SPART_RX_PARITY_EN
        check("rst_parity_err", 32'(parity_err), 32'h0);
`endif
        rst = 1'b0;
        wait_bits(1);

        // Normal byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("norm_rx_data", 32'(rx_data), 32'hA5);
        check("norm_rda", 32'(rda), 32'h1);
        check("norm_frame_err", 32'(frame_err), 32'h0);
        check("norm_overrun", 32'(overrun), 32'h0);
`ifdef SPART_RX_PARITY_EN
        check("norm_parity_err", 32'(parity_err), 32'h0);
`endif
        pulse_ack();
        check("norm_ack_rda", 32'(rda), 32'h0);
        check("norm_ack_rx_data", 32'(rx_data), 32'hA5);
        pulse_ack();
        check("idle_ack_rda", 32'(rda), 32'h0);
        check("idle_ack_overrun", 32'(overrun), 32'h0);

        // False start: 3 ticks low
        rxd = 1'b0;
        wait_clks(3 * baud_div);
        rxd = 1'b1;
        wait_bits(1);
        check("false_state", 32'(dut.state_q), 32'(IDLE));
        check("false_rda", 32'(rda), 32'h0);
        check("false_rx_data", 32'(rx_data), 32'hA5);

        // Framing error, then line held low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clks(4);
        check("frm_rx_data", 32'(rx_data), 32'h3C);
        check("frm_rda", 32'(rda), 32'h1);
        check("frm_frame_err", 32'(frame_err), 32'h1);
        pulse_ack();
        check("frm_ack_rda", 32'(rda), 32'h0);
        wait_bits(11);
        check("frm_low_rda", 32'(rda), 32'h0);
        check("frm_low_state", 32'(dut.state_q), 32'(IDLE));
        rxd = 1'b1;
        wait_bits(1);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_bits(1);
        check("ovr_first_rda", 32'(rda), 32'h1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("ovr_rx_data", 32'(rx_data), 32'h22);
        check("ovr_rda", 32'(rda), 32'h1);
        check("ovr_overrun", 32'(overrun), 32'h1);
        check("ovr_frame_err", 32'(frame_err), 32'h0);
        pulse_ack();
        check("ovr_ack_rda", 32'(rda), 32'h0);
        check("ovr_ack_overrun", 32'(overrun), 32'h0);

        // rd_ack coinciding with completion
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_bits(1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_clks(4);
        check("coin_ack_hit", 32'(ack_hit), 32'h1);
        check("coin_rda", 32'(rda), 32'h1);
        check("coin_rx_data", 32'(rx_data), 32'h22);
        check("coin_overrun", 32'(overrun), 32'h0);

        // Reset during data bit 4 of 0xFF
        rxd = 1'b0;
        wait_bits(1);
        rxd = 1'b1;
        wait_bits(4);
        wait_clks(OS * baud_div / 2);
        rst = 1'b1;
        wait_clks(3);
        check("mrst_rx_data", 32'(rx_data), 32'h00);
        check("mrst_rda", 32'(rda), 32'h0);
        check("mrst_frame_err", 32'(frame_err), 32'h0);
        check("mrst_overrun", 32'(overrun), 32'h0);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        wait_bits(2);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("mrst_next_rx_data", 32'(rx_data), 32'h5A);
        check("mrst_next_rda", 32'(rda), 32'h1);
        check("mrst_next_frame_err", 32'(frame_err), 32'h0);
        pulse_ack();

`ifdef SPART_RX_PARITY_EN
        // Parity: 0x07 has odd weight, even-parity bit must be 1
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("par_bad_rx_data", 32'(rx_data), 32'h07);
        check("par_bad_err", 32'(parity_err), 32'h1);
        pulse_ack();
        wait_bits(1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("par_good_err", 32'(parity_err), 32'h0);
        check("par_good_rda", 32'(rda), 32'h1);
        pulse_ack();
`endif

        // baud_en held high continuously
        baud_div = 1;
        wait_clks(40);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clks(4);
        check("cont_rx_data", 32'(rx_data), 32'h96);
        check("cont_rda", 32'(rda), 32'h1);
        check("cont_frame_err", 32'(frame_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
